// File: rtl/spi_pwm_pkg.sv
// rtl/spi_pwm_pkg.sv - shared frame layout and controller state encoding for the SPI PWM link
package spi_pwm_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int NUM_CHANNELS = 7;
  localparam int WR_BIT       = 15;
  localparam int CH_MSB       = 14;
  localparam int CH_LSB       = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Reads carry a zero duty byte so the driver never sees stale data on a read frame.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic write,
                                                        input logic [2:0] channel,
                                                        input logic [7:0] duty);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[WR_BIT] = write;
    f[CH_MSB:CH_LSB] = channel;
    f[7:0] = write ? duty : 8'h00;
    return f;
  endfunction

endpackage

// File: rtl/spi_pwm_controller_clk_div.sv
// rtl/spi_pwm_controller_clk_div.sv - loadable half-period down-counter for sclk generation
module spi_clk_div #(
  parameter logic [7:0] LOAD_VALUE = 8'd3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  logic [7:0] count;

  // Reload on every state entry; otherwise count down and park at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= LOAD_VALUE;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tick = (count == 8'd0);

endmodule

// File: rtl/spi_pwm_controller.sv
// rtl/spi_pwm_controller.sv - SPI mode-0 master that writes and reads back PWM driver duty bytes
import spi_pwm_pkg::*;

module spi_pwm_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_channel,
  input  logic [7:0] cmd_duty,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_e                state;
  state_e                state_next;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bit_cnt;
  logic [7:0]            rx;
  logic                  tick;
  logic                  load;
  logic                  accept;
  logic                  legal;

  assign accept = cmd_valid & cmd_ready;
  assign legal  = (int'(cmd_channel) < NUM_CHANNELS);
  // Every state change restarts the half-period so LOW and HIGH last exactly CLK_DIV cycles.
  assign load   = (state_next != state);

  spi_clk_div #(
    .LOAD_VALUE(DIV_LOAD)
  ) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and SPI pin drive; sclk/mosi come straight from state so reset clears them at once.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    sclk       = 1'b0;
    mosi       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && legal) begin
          state_next = LOW;
        end
      end
      LOW: begin
        mosi = shift[FRAME_BITS-1];
        if (tick) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        sclk = 1'b1;
        mosi = shift[FRAME_BITS-1];
        if (tick) begin
          state_next = (bit_cnt == 4'd0) ? DONE : LOW;
        end
      end
      DONE: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame shifter, miso capture, response latch and illegal-channel error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      rsp_data <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept & ~legal;
      if (accept && legal) begin
        shift   <= build_frame(cmd_write, cmd_channel, cmd_duty);
        bit_cnt <= LAST_BIT;
      end
      // miso is taken on the edge that raises sclk; only the last 8 bits matter.
      if (state == LOW && tick) begin
        rx <= {rx[6:0], miso};
      end
      if (state == HIGH && tick) begin
        if (bit_cnt == 4'd0) begin
          rsp_data <= rx;
        end else begin
          bit_cnt <= bit_cnt - 4'd1;
          shift   <= {shift[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_controller.sv
// tb/tb_spi_pwm_controller.sv - directed bench for spi_pwm_controller with CLK_DIV 4 and 1
module tb_spi_pwm_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       cmd_valid4 = 1'b0, cmd_write4 = 1'b0;
  logic [2:0] cmd_channel4 = 3'd0;
  logic [7:0] cmd_duty4 = 8'h00;
  logic       cmd_ready4, rsp_valid4, err4, sclk4, mosi4, miso4;
  logic [7:0] rsp_data4;

  logic       cmd_valid1 = 1'b0, cmd_write1 = 1'b0;
  logic [2:0] cmd_channel1 = 3'd0;
  logic [7:0] cmd_duty1 = 8'h00;
  logic       cmd_ready1, rsp_valid1, err1, sclk1, mosi1, miso1;
  logic [7:0] rsp_data1;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] miso_word4 = 16'h0000;
  int          base4 = 0;
  int          rises4 = 0;
  logic        sclk4_q = 1'b0;
  logic [15:0] cap4 = 16'h0000;
  int          idx4;
  int          rises1 = 0;
  logic        sclk1_q = 1'b0;
  logic [15:0] cap1 = 16'h0000;

  always #5 clk = ~clk;

  spi_pwm_controller #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_write(cmd_write4), .cmd_channel(cmd_channel4), .cmd_duty(cmd_duty4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .err(err4),
    .sclk(sclk4), .mosi(mosi4), .miso(miso4)
  );

  spi_pwm_controller #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write1), .cmd_channel(cmd_channel1), .cmd_duty(cmd_duty1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .err(err1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  // Driver model: capture mosi on each sclk rise, count pulses.
  always @(negedge clk) begin
    sclk4_q <= sclk4;
    if (sclk4 && !sclk4_q) begin
      cap4   <= {cap4[14:0], mosi4};
      rises4 <= rises4 + 1;
    end
    sclk1_q <= sclk1;
    if (sclk1 && !sclk1_q) begin
      cap1   <= {cap1[14:0], mosi1};
      rises1 <= rises1 + 1;
    end
  end

  // Driver model: present frame bit k of miso_word4 during frame bit k.
  always_comb begin
    idx4  = rises4 - base4;
    miso4 = (idx4 >= 0 && idx4 < 16) ? miso_word4[4'(15 - idx4)] : 1'b0;
  end
  assign miso1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command on the CLK_DIV=4 instance, scramble inputs after accept, wait for rsp.
  task automatic run4(input logic w, input logic [2:0] ch, input logic [7:0] d,
                      input logic [15:0] mw, output int rcyc, output logic [7:0] rdat,
                      output logic [15:0] frame, output int pulses, output logic busy);
    @(negedge clk);
    miso_word4   = mw;
    base4        = rises4;
    cmd_valid4   = 1'b1;
    cmd_write4   = w;
    cmd_channel4 = ch;
    cmd_duty4    = d;
    @(posedge clk); #1;
    cmd_valid4   = 1'b0;
    cmd_write4   = ~w;
    cmd_channel4 = 3'd1;
    cmd_duty4    = 8'h5A;
    busy  = ~cmd_ready4;
    rcyc  = -1;
    rdat  = 8'h00;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid4) begin
        rcyc = n;
        rdat = rsp_data4;
        break;
      end
      @(posedge clk); #1;
    end
    frame  = cap4;
    pulses = rises4 - base4;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  ch;
    logic [7:0]  duty;
    logic [15:0] mw;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rcyc, pulses, acc2, rsp1, rsp2, nrsp;
    logic [7:0]  rdat;
    logic [15:0] frame, f1, f2;
    logic        busy;

    vecs[0] = '{1'b1, 3'd3, 8'h80, 16'h0000, 16'hB080, 8'h00};
    vecs[1] = '{1'b0, 3'd5, 8'hEE, 16'h003C, 16'h5000, 8'h3C};
    vecs[2] = '{1'b1, 3'd0, 8'hFF, 16'hA5A5, 16'h80FF, 8'hA5};
    vecs[3] = '{1'b0, 3'd6, 8'h77, 16'h1234, 16'h6000, 8'h34};
    vecs[4] = '{1'b1, 3'd6, 8'h01, 16'hFFC3, 16'hE001, 8'hC3};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset cmd_ready", 32'(cmd_ready4), 32'd1);
    check("reset sclk", 32'(sclk4), 32'd0);
    check("reset mosi", 32'(mosi4), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid4), 32'd0);
    check("reset rsp_data", 32'(rsp_data4), 32'h00);
    check("reset err", 32'(err4), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run4(vecs[i].w, vecs[i].ch, vecs[i].duty, vecs[i].mw, rcyc, rdat, frame, pulses, busy);
      check($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      check($sformatf("v%0d rsp_cycle", i), 32'(rcyc), 32'd129);
      check($sformatf("v%0d frame", i), 32'(frame), 32'(vecs[i].frame));
      check($sformatf("v%0d pulses", i), 32'(pulses), 32'd16);
      check($sformatf("v%0d rsp_data", i), 32'(rdat), 32'(vecs[i].rdata));
      @(posedge clk); #1;
      check($sformatf("v%0d ready_after", i), 32'(cmd_ready4), 32'd1);
      check($sformatf("v%0d rsp_pulse_len", i), 32'(rsp_valid4), 32'd0);
      check($sformatf("v%0d rsp_data_held", i), 32'(rsp_data4), 32'(vecs[i].rdata));
    end

    // Illegal channel 7: err pulse only, no SPI activity.
    @(negedge clk);
    base4 = rises4;
    cmd_valid4 = 1'b1; cmd_write4 = 1'b1; cmd_channel4 = 3'd7; cmd_duty4 = 8'h33;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    check("ch7 err", 32'(err4), 32'd1);
    check("ch7 ready", 32'(cmd_ready4), 32'd1);
    check("ch7 sclk", 32'(sclk4), 32'd0);
    @(posedge clk); #1;
    check("ch7 err_pulse_len", 32'(err4), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("ch7 no_sclk", 32'(rises4 - base4), 32'd0);
    check("ch7 ready_later", 32'(cmd_ready4), 32'd1);

    // Back-to-back writes with cmd_valid held high.
    @(negedge clk);
    miso_word4 = 16'h0000; base4 = rises4;
    cmd_valid4 = 1'b1; cmd_write4 = 1'b1; cmd_channel4 = 3'd0; cmd_duty4 = 8'hFF;
    @(posedge clk); #1;
    cmd_channel4 = 3'd6; cmd_duty4 = 8'h01;
    acc2 = -1; rsp1 = -1; f1 = 16'h0000;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid4 && rsp1 < 0) begin
        rsp1 = n;
        f1 = cap4;
      end
      if (cmd_ready4) begin
        acc2 = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rsp2 = -1; f2 = 16'h0000;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid4) begin
        rsp2 = n;
        f2 = cap4;
        cmd_valid4 = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid4 = 1'b0;
    check("b2b rsp1_cycle", 32'(rsp1), 32'd129);
    check("b2b frame1", 32'(f1), 32'h80FF);
    check("b2b accept2_cycle", 32'(acc2), 32'd130);
    check("b2b rsp2_cycle", 32'(rsp2), 32'd129);
    check("b2b frame2", 32'(f2), 32'hE001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b no_third", 32'(cmd_ready4), 32'd1);

    // Reset at cycle 40 of a frame.
    @(negedge clk);
    base4 = rises4;
    cmd_valid4 = 1'b1; cmd_write4 = 1'b1; cmd_channel4 = 3'd0; cmd_duty4 = 8'hFF;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("rst sclk_before", 32'(sclk4), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst sclk", 32'(sclk4), 32'd0);
    check("rst mosi", 32'(mosi4), 32'd0);
    check("rst ready", 32'(cmd_ready4), 32'd1);
    nrsp = 0;
    for (int n = 0; n < 200; n++) begin
      if (rsp_valid4) nrsp++;
      @(posedge clk); #1;
    end
    check("rst no_rsp", 32'(nrsp), 32'd0);

    // CLK_DIV = 1 instance: same write, shorter frame.
    @(negedge clk);
    base4 = rises1;
    cmd_valid1 = 1'b1; cmd_write1 = 1'b1; cmd_channel1 = 3'd3; cmd_duty1 = 8'h80;
    @(posedge clk); #1;
    cmd_valid1 = 1'b0; cmd_duty1 = 8'h00;
    rcyc = -1;
    for (int n = 1; n <= 100; n++) begin
      if (rsp_valid1) begin
        rcyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    check("div1 rsp_cycle", 32'(rcyc), 32'd33);
    check("div1 frame", 32'(cap1), 32'hB080);
    check("div1 pulses", 32'(rises1 - base4), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
